sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge), rst (asynchronous, active-high).
REQ-002 Parameter DSIZE, default 8, SHALL set the data width in bits.
REQ-003 Parameter ASIZE, default 4, SHALL set the depth to 2^ASIZE words (ASIZE >= 2).
REQ-004 Parameter AFULL_TH, default 14, SHALL set the almost-full threshold in words (1..2^ASIZE).
REQ-005 Parameter AEMPTY_TH, default 2, SHALL set the almost-empty threshold in words (0..2^ASIZE-1).
REQ-006 Port clk, input, 1 bit: clock.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port wr, input, 1 bit: write request.
REQ-009 Port wdata, input, DSIZE bits: write data.
REQ-010 Port rd, input, 1 bit: read request, or pop in FWFT mode.
REQ-011 Port rdata, output, DSIZE bits: read data.
REQ-012 Port wfull, output, 1 bit: full.
REQ-013 Port rempty, output, 1 bit: empty.
REQ-014 Port afull, output, 1 bit: count >= AFULL_TH.
REQ-015 Port aempty, output, 1 bit: count <= AEMPTY_TH.
REQ-016 Port count, output, ASIZE+1 bits: number of words held, 0..2^ASIZE.
REQ-017 Port ovf, output, 1 bit: sticky overflow error.
REQ-018 Port udf, output, 1 bit: sticky underflow error.

Function
REQ-019 The block SHALL accept a write on a clk edge when wr=1 and wfull=0, storing wdata at the write pointer.
REQ-020 The block SHALL accept a read on a clk edge when rd=1 and rempty=0.
REQ-021 Pointers SHALL be ASIZE+1-bit binary: the low ASIZE bits address the memory, and the MSB is the wrap bit that distinguishes full from empty.
REQ-022 count SHALL equal (wptr - rptr) mod 2^(ASIZE+1) and SHALL update on the same edge as the accepted operation; a simultaneous accepted read and write leaves count unchanged.
REQ-023 wfull, rempty, afull and aempty SHALL be registered and SHALL reflect count after the current edge, with no extra cycle of lag.
REQ-024 A write while wfull=1 SHALL be dropped, leaving storage, pointers and count unchanged, and SHALL set ovf until reset.
REQ-025 A read while rempty=1 SHALL be ignored and SHALL set udf until reset.
REQ-026 When full, wr=1 with rd=1: the read SHALL be accepted, the write rejected, and ovf set.
REQ-027 When empty (standard mode), wr=1 with rd=1: the write SHALL be accepted, the read rejected, and udf set.
REQ-028 Standard mode: rdata SHALL be registered with 1-cycle read latency (data valid the cycle after the accepted read) and SHALL hold its value otherwise.
REQ-029 Pointer wrap from 2^(ASIZE+1)-1 to 0 SHALL be seamless, with no loss of ordering or flag error.

Reset
REQ-030 While rst=1, the block SHALL clear both pointers to 0 asynchronously.
REQ-031 While rst=1, the outputs SHALL be: count=0, wfull=0, rempty=1, afull=0, aempty=1, ovf=0, udf=0, rdata=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all held words.
REQ-034 The first accepted operation after reset SHALL occur on the first clk edge after rst falls.

Configuration
REQ-035 Macro SYNC_FIFO_FWFT_EN, when defined, SHALL select first-word-fall-through mode via an output register stage.
REQ-036 FWFT mode: rdata SHALL present the head word whenever rempty=0, and rd SHALL pop it, so the next word appears on rdata after the same edge.
REQ-037 FWFT mode: a write into an empty FIFO SHALL bypass memory into the output register, with rempty=0 and rdata valid on the cycle after the write edge.
REQ-038 FWFT mode: count SHALL include the output-register word, and total capacity SHALL remain 2^ASIZE words.
REQ-039 FWFT mode: wr with rd while count=1 SHALL pop the head word and load the new word into the output register, leaving count=1.
REQ-040 Without SYNC_FIFO_FWFT_EN, the block SHALL behave per REQ-028, with no output-register bypass logic.

Structure
REQ-041 Package fifo_pkg SHALL hold the default DSIZE, ASIZE and threshold constants and the count-width calculation.
REQ-042 Sub-module sync_fifo_mem SHALL implement the storage as a 2^ASIZE x DSIZE dual-port array with synchronous write and asynchronous read.

Verification
REQ-043 Fill test (defaults): 16 writes of 0x00..0x0F with rd=0 SHALL give wfull=1 and count=16 after the 16th edge; a 17th write of 0xAA SHALL set ovf=1, and count SHALL remain 16.
REQ-044 Drain test: 16 reads after the fill test SHALL return 0x00..0x0F in order, ending with rempty=1 and count=0; a 17th read SHALL set udf=1.
REQ-045 Threshold test: afull SHALL rise at count=14, and aempty SHALL fall at count=3 on the fill and rise at count=2 on the drain.
REQ-046 Wrap test: 40 continuous wr+rd cycles at count=5 SHALL leave count at 5 throughout, with data order intact across a pointer wrap.
REQ-047 Reset test: rst pulsed mid-clock at count=9 SHALL immediately give count=0, rempty=1, wfull=0 and ovf=udf=0.
REQ-048 FWFT test (SYNC_FIFO_FWFT_EN): a write of 0x5C into an empty FIFO SHALL give rdata=0x5C with rempty=0 one cycle later; rd then SHALL give rempty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, count-width helper and status-flag type for the synchronous FIFO.
package fifo_pkg;

  localparam int DSIZE_DEF     = 8;
  localparam int ASIZE_DEF     = 4;
  localparam int AFULL_TH_DEF  = 14;
  localparam int AEMPTY_TH_DEF = 2;

  // The extra bit lets count reach 2^ASIZE and gives the pointers their wrap bit.
  function automatic int count_width(input int asize);
    return asize + 1;
  endfunction

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{wfull: 1'b0, rempty: 1'b1, afull: 1'b0, aempty: 1'b1};

  function automatic fifo_flags_t flags_for(input int cnt, input int depth,
                                            input int afull_th, input int aempty_th);
    fifo_flags_t f;
    f.wfull  = (cnt == depth);
    f.rempty = (cnt == 0);
    f.afull  = (cnt >= afull_th);
    f.aempty = (cnt <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// 2^ASIZE x DSIZE dual-port storage: synchronous write port, asynchronous read port.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // NOTE: storage has no reset; only the pointers decide which words are valid,
  // so resetting the array would cost a clear path for no functional gain.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags, sticky ovf/udf and occupancy count.
// Define SYNC_FIFO_FWFT_EN to build first-word-fall-through mode with an output register.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int ASIZE     = ASIZE_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   count,
  output logic             ovf,
  output logic             udf
);

  localparam int            CW    = count_width(ASIZE);
  localparam int            DEPTH = 1 << ASIZE;
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0]    wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  fifo_flags_t      flags_q, flags_nxt;
  logic             ovf_q, udf_q;
  logic             wr_ok, rd_ok, mem_we, rd_adv;
  logic [DSIZE-1:0] mem_rdata, rdata_q;

  // Full takes priority over a write, empty over a read; the other side of a
  // simultaneous request still proceeds.
  assign wr_ok = wr & ~flags_q.wfull;
  assign rd_ok = rd & ~flags_q.rempty;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_nxt = count_q;
    if (wr_ok && !rd_ok)      count_nxt = count_q + ONE;
    else if (!wr_ok && rd_ok) count_nxt = count_q - ONE;
  end

  // Flags are registered from the post-edge count, so they never lag count.
  assign flags_nxt = flags_for(int'(count_nxt), DEPTH, AFULL_TH, AEMPTY_TH);

  assign wptr_nxt = mem_we ? wptr_q + ONE : wptr_q;
  assign rptr_nxt = rd_adv ? rptr_q + ONE : rptr_q;

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The head word lives in rdata_q; memory holds only the words behind it,
  // so the memory is always empty whenever the output register is.
  logic ovalid_q, ovalid_nxt, mem_empty, bypass;

  assign mem_empty = (wptr_q == rptr_q);
  assign bypass    = wr_ok & mem_empty & (~ovalid_q | rd_ok);
  assign rd_adv    = rd_ok & ~mem_empty;
  assign mem_we    = wr_ok & ~bypass;

  always_comb begin
    ovalid_nxt = ovalid_q;
    if (bypass || rd_adv) ovalid_nxt = 1'b1;
    else if (rd_ok)       ovalid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ovalid_q <= ovalid_nxt;
      if (bypass)      rdata_q <= wdata;
      else if (rd_adv) rdata_q <= mem_rdata;
    end
  end
`else
  assign mem_we = wr_ok;
  assign rd_adv = rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_q <= '0;
    else if (rd_ok) rdata_q <= mem_rdata;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= FLAGS_RESET;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_nxt;
      rptr_q  <= rptr_nxt;
      count_q <= count_nxt;
      flags_q <= flags_nxt;
      if (wr && flags_q.wfull)  ovf_q <= 1'b1;
      if (rd && flags_q.rempty) udf_q <= 1'b1;
    end
  end

  assign rdata  = rdata_q;
  assign wfull  = flags_q.wfull;
  assign rempty = flags_q.rempty;
  assign afull  = flags_q.afull;
  assign aempty = flags_q.aempty;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       wfull, rempty, afull, aempty, ovf, udf;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a queue of held words plus sticky error bits.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_rdata;

  sync_fifo dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .wdata  (wdata),
    .rd     (rd),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty),
    .afull  (afull),
    .aempty (aempty),
    .count  (count),
    .ovf    (ovf),
    .udf    (udf)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = 8'h00;
  endtask

  // One clock of traffic; the model is advanced from the pre-edge state and all outputs compared.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    bit         full_b, empty_b;
    logic [7:0] head;
    int         sz;
    wr = w; rd = r; wdata = d;
    @(posedge clk);
    full_b  = (mq.size() == DEPTH);
    empty_b = (mq.size() == 0);
    if (w && full_b)  m_ovf = 1'b1;
    if (r && empty_b) m_udf = 1'b1;
    if (r && !empty_b) begin
      head    = mq.pop_front();
      m_rdata = head;
    end
    if (w && !full_b) mq.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    if (mq.size() > 0) m_rdata = mq[0];
`endif
    #1;
    wr = 1'b0; rd = 1'b0;
    sz = mq.size();
    n_cmp++; if (int'(count) !== sz) begin n_bad++; $display("FAIL %s count: got %0d expected %0d", tag, count, sz); end
    n_cmp++; if (wfull !== (sz == DEPTH)) begin n_bad++; $display("FAIL %s wfull: got %b expected %b", tag, wfull, sz == DEPTH); end
    n_cmp++; if (rempty !== (sz == 0)) begin n_bad++; $display("FAIL %s rempty: got %b expected %b", tag, rempty, sz == 0); end
    n_cmp++; if (afull !== (sz >= 14)) begin n_bad++; $display("FAIL %s afull: got %b expected %b", tag, afull, sz >= 14); end
    n_cmp++; if (aempty !== (sz <= 2)) begin n_bad++; $display("FAIL %s aempty: got %b expected %b", tag, aempty, sz <= 2); end
    n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL %s ovf: got %b expected %b", tag, ovf, m_ovf); end
    n_cmp++; if (udf !== m_udf) begin n_bad++; $display("FAIL %s udf: got %b expected %b", tag, udf, m_udf); end
    n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL %s rdata: got %02h expected %02h", tag, rdata, m_rdata); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    #12;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset count: got %0d expected 0", count); end
    n_cmp++; if (wfull !== 1'b0 || afull !== 1'b0) begin n_bad++; $display("FAIL reset wfull/afull: got %b%b expected 00", wfull, afull); end
    n_cmp++; if (rempty !== 1'b1 || aempty !== 1'b1) begin n_bad++; $display("FAIL reset rempty/aempty: got %b%b expected 11", rempty, aempty); end
    n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_bad++; $display("FAIL reset ovf/udf: got %b%b expected 00", ovf, udf); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset rdata: got %02h expected 00", rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), "fill");
      if (i == 12) begin
        n_cmp++; if (afull !== 1'b0) begin n_bad++; $display("FAIL fill afull@13: got %b expected 0", afull); end
      end
      if (i == 13) begin
        n_cmp++; if (afull !== 1'b1) begin n_bad++; $display("FAIL fill afull@14: got %b expected 1", afull); end
      end
      if (i == 1) begin
        n_cmp++; if (aempty !== 1'b1) begin n_bad++; $display("FAIL fill aempty@2: got %b expected 1", aempty); end
      end
      if (i == 2) begin
        n_cmp++; if (aempty !== 1'b0) begin n_bad++; $display("FAIL fill aempty@3: got %b expected 0", aempty); end
      end
    end
    n_cmp++; if (wfull !== 1'b1 || count !== 5'd16) begin n_bad++; $display("FAIL fill full: got wfull=%b count=%0d expected 1/16", wfull, count); end
    step(1'b1, 1'b0, 8'hAA, "overflow");
    n_cmp++; if (ovf !== 1'b1 || count !== 5'd16) begin n_bad++; $display("FAIL overflow: got ovf=%b count=%0d expected 1/16", ovf, count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(i)) begin n_bad++; $display("FAIL drain head: got %02h expected %02h", rdata, 8'(i)); end
`endif
      step(1'b0, 1'b1, 8'h00, "drain");
`ifndef SYNC_FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(i)) begin n_bad++; $display("FAIL drain order: got %02h expected %02h", rdata, 8'(i)); end
`endif
      if (i == 12) begin
        n_cmp++; if (aempty !== 1'b0) begin n_bad++; $display("FAIL drain aempty@3: got %b expected 0", aempty); end
      end
      if (i == 13) begin
        n_cmp++; if (aempty !== 1'b1) begin n_bad++; $display("FAIL drain aempty@2: got %b expected 1", aempty); end
      end
    end
    n_cmp++; if (rempty !== 1'b1 || count !== 5'd0) begin n_bad++; $display("FAIL drain empty: got rempty=%b count=%0d expected 1/0", rempty, count); end
    step(1'b0, 1'b1, 8'h00, "underflow");
    n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL underflow: got udf=%b expected 1", udf); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "wrap_pre");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), "wrap");
      n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL wrap count: got %0d expected 5", count); end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "wrap_post");
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b1, 8'h3C, "empty_wr_rd");
    n_cmp++; if (udf !== 1'b1 || count !== 5'd1) begin n_bad++; $display("FAIL empty_wr_rd: got udf=%b count=%0d expected 1/1", udf, count); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'($urandom), "top_up");
    step(1'b1, 1'b1, 8'hEE, "full_wr_rd");
    n_cmp++; if (ovf !== 1'b1 || count !== 5'd15) begin n_bad++; $display("FAIL full_wr_rd: got ovf=%b count=%0d expected 1/15", ovf, count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b1, 8'h00, "pre_udf");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom), "to9");
    step(1'b1, 1'b0, 8'hAB, "to10");
    step(1'b0, 1'b1, 8'h00, "back9");
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin n_bad++; $display("FAIL midreset flags: got count=%0d rempty=%b wfull=%b expected 0/1/0", count, rempty, wfull); end
    n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_bad++; $display("FAIL midreset errs: got ovf=%b udf=%b expected 0/0", ovf, udf); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h77, "post_reset");
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL post_reset first write: got count=%0d expected 1", count); end
  endtask

  task automatic test_fwft();
`ifdef SYNC_FIFO_FWFT_EN
    do_reset();
    step(1'b1, 1'b0, 8'h5C, "fwft_wr");
    n_cmp++; if (rdata !== 8'h5C || rempty !== 1'b0) begin n_bad++; $display("FAIL fwft bypass: got rdata=%02h rempty=%b expected 5c/0", rdata, rempty); end
    step(1'b1, 1'b1, 8'h91, "fwft_swap");
    n_cmp++; if (rdata !== 8'h91 || count !== 5'd1) begin n_bad++; $display("FAIL fwft swap: got rdata=%02h count=%0d expected 91/1", rdata, count); end
    step(1'b0, 1'b1, 8'h00, "fwft_pop");
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL fwft pop: got rempty=%b expected 1", rempty); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Bias toward writes in the first half and reads in the second to visit both ends.
      logic w, r;
      w = ($urandom_range(99) < ((i < 200) ? 65 : 35));
      r = ($urandom_range(99) < ((i < 200) ? 35 : 65));
      step(w, r, 8'($urandom), "random");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_fwft();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
